// File: rtl/sequencer_pkg.sv
// Shared definitions for the note sequencer: length width, wr_data field
// positions, the one-hot state encoding and the queued note record.
package sequencer_pkg;

  localparam int LEN_W    = 32;
  localparam int DATA_W   = 2 * LEN_W;

  // wr_data = {hold_len, gap_len}
  localparam int HOLD_MSB = 2 * LEN_W - 1;
  localparam int HOLD_LSB = LEN_W;
  localparam int GAP_MSB  = LEN_W - 1;
  localparam int GAP_LSB  = 0;

  typedef logic [LEN_W-1:0] len_t;

  typedef enum logic [5:0] {
    IDLE      = 6'b000001,
    TRIGGER   = 6'b000010,
    HOLD      = 6'b000100,
    OFF       = 6'b001000,
    WAIT_DONE = 6'b010000,
    GAP       = 6'b100000
  } state_t;

  typedef struct packed {
    len_t hold_len;
    len_t gap_len;
  } note_t;

  function automatic note_t unpack_note(input logic [DATA_W-1:0] raw);
    note_t n;
    n.hold_len = raw[HOLD_MSB:HOLD_LSB];
    n.gap_len  = raw[GAP_MSB:GAP_LSB];
    return n;
  endfunction

endpackage

// File: rtl/note_fifo.sv
// First-word-fall-through queue of note events. head always shows the oldest
// entry while empty is low; a push into a full queue is taken only when a
// pop happens in the same cycle.
module note_fifo
  import sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset flushes the queue.
  // NOTE: state registers use non-blocking (<=) so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write port.
  // NOTE: the array is deliberately not reset; emptiness is tracked by count, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/note_sequencer.sv
// Plays queued note events into an envelope generator: trigger, hold for
// hold_len cycles, release, wait for release-complete (bounded by TIMEOUT),
// then rest for gap_len cycles before the next note.
module note_sequencer
  import sequencer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              stop,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              env_busy,
  input  logic              env_done,
  output logic              note_on,
  output logic              note_off,
  output logic              full,
  output logic              empty,
  output logic              seq_busy,
  output logic [7:0]        notes_played,
  output logic              overflow,
  output logic              timeout
);

  state_t            state;
  state_t            state_next;
  len_t              cnt;
  len_t              cnt_next;
  len_t              cnt_inc;
  note_t             cur;
  logic [DATA_W-1:0] head;
  logic              pop;
  logic              armed;
  logic              start;
  logic              set_timeout;
  logic              note_done;

  note_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign cnt_inc  = cnt + 1'b1;
  assign start    = run && armed && !stop && !empty && !env_busy;
  assign seq_busy = (state != IDLE);

  // Next-state, phase counter and pop decisions.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    pop         = 1'b0;
    set_timeout = 1'b0;
    note_done   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          pop        = 1'b1;
          state_next = TRIGGER;
        end
      end
      TRIGGER: begin
        // cnt counts cycles since note_on rose.
        cnt_next = len_t'(1);
        if (stop || cur.hold_len <= len_t'(1)) state_next = OFF;
        else                                   state_next = HOLD;
      end
      HOLD: begin
        if (stop || cnt_inc >= cur.hold_len) state_next = OFF;
        else                                 cnt_next   = cnt_inc;
      end
      OFF: begin
        // cnt counts cycles since note_off rose.
        cnt_next = len_t'(1);
        if (env_done) begin
          cnt_next   = '0;
          state_next = GAP;
        end else if (TIMEOUT <= 1) begin
          cnt_next    = '0;
          set_timeout = 1'b1;
          state_next  = GAP;
        end else begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (env_done) begin
          cnt_next   = '0;
          state_next = GAP;
        end else if (cnt_inc >= len_t'(TIMEOUT)) begin
          cnt_next    = '0;
          set_timeout = 1'b1;
          state_next  = GAP;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      GAP: begin
        // A gap_len of 0 still rests for one cycle.
        if (cnt_inc >= cur.gap_len) begin
          note_done  = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counters, registered strobes and sticky status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      cur          <= '0;
      armed        <= 1'b1;
      note_on      <= 1'b0;
      note_off     <= 1'b0;
      notes_played <= '0;
      overflow     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      note_on  <= (state_next == TRIGGER);
      note_off <= (state_next == OFF);
      if (pop) cur <= unpack_note(head);
      // A stop disarms; run must be seen low before another note may start.
      if (stop)      armed <= 1'b0;
      else if (!run) armed <= 1'b1;
      if (note_done)                 notes_played <= notes_played + 1'b1;
      if (set_timeout)               timeout      <= 1'b1;
      if (wr_en && full && !pop)     overflow     <= 1'b1;
    end
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of note-event entries in the queue (power of two, at least 2).
REQ-002 SHALL have parameter TIMEOUT, default 1024: maximum cycles to wait for env_done after note_off.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port run, input, 1 bit: level; sequencing enabled while high.
REQ-006 SHALL have port stop, input, 1 bit: pulse; abort the current note and clear the run latch.
REQ-007 SHALL have port wr_en, input, 1 bit: enqueue strobe.
REQ-008 SHALL have port wr_data, input, 64 bits: {hold_len[31:0], gap_len[31:0]}, both in cycles.
REQ-009 SHALL have port env_busy, input, 1 bit: envelope generator busy.
REQ-010 SHALL have port env_done, input, 1 bit: envelope generator release-complete pulse.
REQ-011 SHALL have port note_on, output, 1 bit: one-cycle trigger to the envelope generator.
REQ-012 SHALL have port note_off, output, 1 bit: one-cycle release to the envelope generator.
REQ-013 SHALL have ports full and empty, output, 1 bit each: queue status.
REQ-014 SHALL have port seq_busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port notes_played, output, 8 bits: count of completed notes, wraps 255->0.
REQ-016 SHALL have ports overflow and timeout, output, 1 bit each: sticky error flags, cleared only by rst.

Function
REQ-017 SHALL implement one-hot states IDLE, TRIGGER, HOLD, OFF, WAIT_DONE, GAP.
REQ-018 IDLE SHALL move to TRIGGER in cycle N+1 when, in cycle N, run is high, empty is low and env_busy is low; the head entry is popped in cycle N.
REQ-019 SHALL hold note_on high exactly in the TRIGGER cycle and note_off high exactly in the OFF cycle; both SHALL be registered outputs.
REQ-020 SHALL raise note_off exactly hold_len cycles after note_on rises; hold_len of 0 or 1 SHALL skip HOLD (TRIGGER goes directly to OFF).
REQ-021 SHALL accept an env_done sampled high in OFF or WAIT_DONE; the state SHALL be GAP on the following cycle.
REQ-022 SHALL, if env_done is not seen within TIMEOUT cycles after OFF, set timeout and enter GAP.
REQ-023 GAP SHALL last max(gap_len,1) cycles, then return to IDLE and increment notes_played in the same edge.
REQ-024 SHALL make a stop pulse in TRIGGER or HOLD go to OFF next cycle; in OFF, WAIT_DONE or GAP it SHALL complete normally; the run latch SHALL clear so no further note starts until run is low for at least one cycle and then high again.
REQ-025 SHALL ignore a write when full is high and set overflow, except when a pop occurs in the same cycle, in which case the write is accepted.
REQ-026 SHALL ignore env_done outside OFF and WAIT_DONE.
REQ-027 SHALL keep counters at 32 bits, unsigned, comparing the incremented count against the target (no off-by-one wrap).

Reset
REQ-028 SHALL, while rst is high, force the state to IDLE and flush the queue (empty=1, full=0), regardless of clk.
REQ-029 SHALL, while rst is high, drive note_on, note_off, seq_busy, notes_played, overflow and timeout to 0.
REQ-030 SHALL, on a reset taken mid-note, issue no note_off after release.

Structure
REQ-031 SHALL place the state encodings, the 32-bit length width and the wr_data field positions in a shared package, sequencer_pkg.
REQ-032 SHALL implement the queue as sub-module note_fifo (synchronous, first-word-fall-through, DEPTH entries, full/empty, simultaneous push/pop).

Verification
REQ-033 SHALL verify a single note: enqueue {5,3}, run=1, env_done 4 cycles after note_off -> note_on at T, note_off at T+5, next IDLE at done+4, notes_played=1.
REQ-034 SHALL verify hold_len=0: enqueue {0,1} -> note_off exactly 1 cycle after note_on.
REQ-035 SHALL verify full-queue writes: fill 4 entries, write a 5th without a pop -> overflow=1 and 4 entries played; repeat the 5th write in the pop cycle -> accepted, overflow stays 0.
REQ-036 SHALL verify stop: stop in HOLD of {100,2} -> note_off next cycle; the queued second note does not start until run toggles.
REQ-037 SHALL verify timeout: env_done never asserted, TIMEOUT=16 -> timeout=1 sixteen cycles after note_off, GAP entered.
REQ-038 SHALL verify mid-operation reset: rst asserted during WAIT_DONE with 2 queued -> all outputs 0, empty=1, no note_on after release.
